// File: rtl/vrf_pkg.sv
// Shared constants and the lane-vector type for the vector register file.
package vrf_pkg;
  localparam int VRF_REG_WIDTH = 8;
  localparam int VRF_REG_COUNT = 16;
  localparam int VRF_SEL_BITS  = $clog2(VRF_REG_COUNT);
  localparam int VRF_LANES     = 4;

  typedef logic [VRF_LANES-1:0][VRF_REG_WIDTH-1:0] lane_vec_t;
endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register busy bits tracking in-flight producers, plus a sticky
// write-after-write error flag. Register 0 is never tracked.
module vrf_scoreboard #(
  parameter int REG_COUNT = 16,
  parameter int SEL_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en,
  input  logic [SEL_BITS-1:0]  iss_sel,
  input  logic                 wr_en,
  input  logic [SEL_BITS-1:0]  wr_sel,
  output logic [REG_COUNT-1:0] busy,
  output logic                 waw_err
);
  logic [REG_COUNT-1:1] busy_reg;
  logic                 waw_err_reg;
  logic                 waw_hit;

  assign busy    = {busy_reg, 1'b0};
  assign waw_err = waw_err_reg;

  // A same-cycle retiring write to the target means the old producer is done.
  assign waw_hit = iss_en && (iss_sel != '0) && busy[iss_sel] &&
                   !(wr_en && (wr_sel == iss_sel));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg    <= '0;
      waw_err_reg <= 1'b0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        // New producer wins over a retiring one on the same register.
        if (iss_en && (iss_sel == SEL_BITS'(r)))
          busy_reg[r] <= 1'b1;
        else if (wr_en && (wr_sel == SEL_BITS'(r)))
          busy_reg[r] <= 1'b0;
      end
      if (waw_hit)
        waw_err_reg <= 1'b1;
    end
  end
endmodule

// File: rtl/vec_regfile_sb.sv
// Vector register file with masked/broadcast writeback and a busy scoreboard.
// Define VRF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module vec_regfile_sb
  import vrf_pkg::*;
#(
  parameter int REG_WIDTH = VRF_REG_WIDTH,
  parameter int REG_COUNT = VRF_REG_COUNT,
  parameter int SEL_BITS  = VRF_SEL_BITS,
  parameter int LANES     = VRF_LANES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SEL_BITS-1:0]             rd_sel1,
  input  logic [SEL_BITS-1:0]             rd_sel2,
  output logic [LANES-1:0][REG_WIDTH-1:0] operand1,
  output logic [LANES-1:0][REG_WIDTH-1:0] operand2,
  output logic                            busy1,
  output logic                            busy2,
  input  logic                            wr_en,
  input  logic [SEL_BITS-1:0]             wr_sel,
  input  logic                            wr_scalar,
  input  logic [LANES-1:0]                wr_mask,
  input  logic [LANES-1:0][REG_WIDTH-1:0] wr_data,
  input  logic                            iss_en,
  input  logic [SEL_BITS-1:0]             iss_sel,
  output logic                            waw_err
);
  typedef logic [LANES-1:0][REG_WIDTH-1:0] vec_t;

  vec_t                 regs_reg [REG_COUNT];
  vec_t                 eff_data;
  logic [REG_COUNT-1:0] busy_vec;

  vrf_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .SEL_BITS  (SEL_BITS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .iss_en  (iss_en),
    .iss_sel (iss_sel),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .busy    (busy_vec),
    .waw_err (waw_err)
  );

  always_comb begin
    eff_data = '0;
    for (int l = 0; l < LANES; l++)
      eff_data[l] = wr_scalar ? wr_data[0] : wr_data[l];
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++)
        regs_reg[r] <= '0;
    end else if (wr_en && (wr_sel != '0)) begin
      for (int l = 0; l < LANES; l++)
        if (wr_mask[l])
          regs_reg[wr_sel][l] <= eff_data[l];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [SEL_BITS-1:0] sel;
    vec_t                rd_data;
    logic                rd_busy;

    assign sel = (gi == 0) ? rd_sel1 : rd_sel2;
`ifdef VRF_BYPASS_EN
    logic hit;
    // Reset suppresses forwarding so the ports read the cleared state.
    assign hit = wr_en && !rst && (wr_sel == sel) && (wr_sel != '0);

    always_comb begin
      rd_data = regs_reg[sel];
      for (int l = 0; l < LANES; l++)
        if (hit && wr_mask[l])
          rd_data[l] = eff_data[l];
    end
    assign rd_busy = busy_vec[sel] & ~hit;
`else
    assign rd_data = regs_reg[sel];
    assign rd_busy = busy_vec[sel];
`endif
  end

  assign operand1 = g_rd[0].rd_data;
  assign operand2 = g_rd[1].rd_data;
  assign busy1    = g_rd[0].rd_busy;
  assign busy2    = g_rd[1].rd_busy;
endmodule

// File: tb/tb_vec_regfile_sb.sv
// Directed table plus randomized run of vec_regfile_sb against a behavioural model.
module tb_vec_regfile_sb;
  import vrf_pkg::*;

`ifdef VRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      rd_sel1, rd_sel2, wr_sel, iss_sel;
  lane_vec_t       operand1, operand2, wr_data;
  logic            busy1, busy2, wr_en, wr_scalar, iss_en, waw_err;
  logic [3:0]      wr_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_sel1   (rd_sel1),
    .rd_sel2   (rd_sel2),
    .operand1  (operand1),
    .operand2  (operand2),
    .busy1     (busy1),
    .busy2     (busy2),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_scalar (wr_scalar),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_sel   (iss_sel),
    .waw_err   (waw_err)
  );

  // Behavioural model: plain arrays of register contents and producer flags.
  lane_vec_t m_regs [16];
  bit        m_busy [16];
  bit        m_waw;

  function automatic lane_vec_t lane_value();
    lane_vec_t v;
    for (int l = 0; l < 4; l++)
      v[l] = wr_scalar ? wr_data[0] : wr_data[l];
    return v;
  endfunction

  function automatic bit fwd(input logic [3:0] sel);
    return BYP && !rst && wr_en && (wr_sel == sel) && (sel != 4'd0);
  endfunction

  function automatic lane_vec_t m_read(input logic [3:0] sel);
    lane_vec_t v = m_regs[sel];
    lane_vec_t w = lane_value();
    if (fwd(sel))
      for (int l = 0; l < 4; l++)
        if (wr_mask[l]) v[l] = w[l];
    return v;
  endfunction

  function automatic bit m_busy_rd(input logic [3:0] sel);
    return fwd(sel) ? 1'b0 : m_busy[sel];
  endfunction

  task automatic m_update();
    lane_vec_t w = lane_value();
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      m_waw = 1'b0;
    end else begin
      if (iss_en && iss_sel != 0 && m_busy[iss_sel] && !(wr_en && wr_sel == iss_sel))
        m_waw = 1'b1;
      if (wr_en) begin
        m_busy[wr_sel] = 1'b0;
        if (wr_sel != 0)
          for (int l = 0; l < 4; l++)
            if (wr_mask[l]) m_regs[wr_sel][l] = w[l];
      end
      if (iss_en && iss_sel != 0)
        m_busy[iss_sel] = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] rd1, rd2;
    bit         wr_en;
    logic [3:0] wr_sel;
    bit         scalar;
    logic [3:0] mask;
    logic [31:0] data;
    bit         iss_en;
    logic [3:0] iss_sel;
    logic [31:0] e_op1, e_op2;
    bit         e_b1, e_b2, e_waw;
  } vec_rec_t;

  vec_rec_t tbl [$];

  task automatic add(input bit r, input logic [3:0] rd1, input logic [3:0] rd2,
                     input bit we, input logic [3:0] ws, input bit sc, input logic [3:0] mk,
                     input logic [31:0] d, input bit ie, input logic [3:0] is,
                     input logic [31:0] o1, input logic [31:0] o2,
                     input bit b1, input bit b2, input bit ww);
    vec_rec_t v;
    v.rst = r; v.rd1 = rd1; v.rd2 = rd2; v.wr_en = we; v.wr_sel = ws; v.scalar = sc;
    v.mask = mk; v.data = d; v.iss_en = ie; v.iss_sel = is;
    v.e_op1 = o1; v.e_op2 = o2; v.e_b1 = b1; v.e_b2 = b2; v.e_waw = ww;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit r, input logic [3:0] rd1, input logic [3:0] rd2,
                       input bit we, input logic [3:0] ws, input bit sc, input logic [3:0] mk,
                       input logic [31:0] d, input bit ie, input logic [3:0] is);
    rst = r; rd_sel1 = rd1; rd_sel2 = rd2; wr_en = we; wr_sel = ws; wr_scalar = sc;
    wr_mask = mk; wr_data = d; iss_en = ie; iss_sel = is;
  endtask

  task automatic advance();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    @(negedge clk);
    advance();

    add(0, 3, 2, 1, 5, 0, 4'hF, 32'h44332211, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    add(0, 5, 2, 1, 5, 0, 4'h5, 32'hFFFFFFFF, 0, 0,
        BYP ? 32'h44FF22FF : 32'h44332211, 32'h0, 0, 0, 0);
    add(0, 5, 2, 1, 2, 1, 4'hF, 32'h0000007A, 0, 0,
        32'h44FF22FF, BYP ? 32'h7A7A7A7A : 32'h0, 0, 0, 0);
    add(0, 2, 2, 0, 0, 0, 4'h0, 32'h0, 1, 4, 32'h7A7A7A7A, 32'h7A7A7A7A, 0, 0, 0);
    add(0, 4, 2, 0, 0, 0, 4'h0, 32'h0, 1, 4, 32'h0, 32'h7A7A7A7A, 1, 0, 0);
    add(0, 4, 2, 1, 4, 0, 4'h0, 32'h0, 1, 4, 32'h0, 32'h7A7A7A7A, !BYP, 0, 1);
    add(0, 4, 2, 1, 4, 0, 4'h0, 32'h0, 0, 0, 32'h0, 32'h7A7A7A7A, !BYP, 0, 1);
    add(0, 4, 2, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 32'h7A7A7A7A, 0, 0, 1);
    add(1, 4, 2, 1, 2, 0, 4'hF, 32'h11111111, 1, 3, 32'h0, 32'h7A7A7A7A, 0, 0, 1);
    add(0, 0, 3, 1, 0, 0, 4'hF, 32'hAAAAAAAA, 1, 0, 32'h0, 32'h0, 0, 0, 0);
    add(0, 0, 2, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    add(0, 6, 0, 1, 6, 0, 4'hF, 32'h5C5C5C5C, 0, 0,
        BYP ? 32'h5C5C5C5C : 32'h0, 32'h0, 0, 0, 0);
    add(0, 6, 0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h5C5C5C5C, 32'h0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rd1, tbl[i].rd2, tbl[i].wr_en, tbl[i].wr_sel,
            tbl[i].scalar, tbl[i].mask, tbl[i].data, tbl[i].iss_en, tbl[i].iss_sel);
      #1;
      $display("dir %0d: rst=%0d rd1=%0d rd2=%0d wr=%0d/%0d iss=%0d/%0d op1=%h busy1=%0d waw=%0d",
               i, rst, rd_sel1, rd_sel2, wr_en, wr_sel, iss_en, iss_sel, operand1, busy1, waw_err);
      check($sformatf("dir%0d_op1", i), 64'(operand1), 64'(tbl[i].e_op1));
      check($sformatf("dir%0d_op2", i), 64'(operand2), 64'(tbl[i].e_op2));
      check($sformatf("dir%0d_busy1", i), 64'(busy1), 64'(tbl[i].e_b1));
      check($sformatf("dir%0d_busy2", i), 64'(busy2), 64'(tbl[i].e_b2));
      check($sformatf("dir%0d_waw", i), 64'(waw_err), 64'(tbl[i].e_waw));
      advance();
    end

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(49) == 0), 4'($urandom), 4'($urandom),
            ($urandom_range(1) == 1), 4'($urandom), ($urandom_range(3) == 0),
            4'($urandom), $urandom, ($urandom_range(2) == 0), 4'($urandom));
      #1;
      $display("rnd %0d: rst=%0d rd1=%0d rd2=%0d wr=%0d/%0d m=%h iss=%0d/%0d op1=%h op2=%h waw=%0d",
               n, rst, rd_sel1, rd_sel2, wr_en, wr_sel, wr_mask, iss_en, iss_sel,
               operand1, operand2, waw_err);
      check($sformatf("rnd%0d_op1", n), 64'(operand1), 64'(m_read(rd_sel1)));
      check($sformatf("rnd%0d_op2", n), 64'(operand2), 64'(m_read(rd_sel2)));
      check($sformatf("rnd%0d_busy1", n), 64'(busy1), 64'(m_busy_rd(rd_sel1)));
      check($sformatf("rnd%0d_busy2", n), 64'(busy2), 64'(m_busy_rd(rd_sel2)));
      check($sformatf("rnd%0d_waw", n), 64'(waw_err), 64'(m_waw));
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_regfile_sb.md
VEC_REGFILE_SB -- requirements
Module: vec_regfile_sb

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, bits per lane element.
REQ-002 SHALL have parameter REG_COUNT, default 16, number of vector registers.
REQ-003 SHALL have parameter SEL_BITS, default 4, register select width, equal to clog2(REG_COUNT).
REQ-004 SHALL have parameter LANES, default 4, elements per vector register.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports rd_sel1 and rd_sel2, input, SEL_BITS, read-port register selects.
REQ-008 SHALL have ports operand1 and operand2, output, LANES x REG_WIDTH, read-port data.
REQ-009 SHALL have ports busy1 and busy2, output, 1, scoreboard busy bit of rd_sel1 and rd_sel2.
REQ-010 SHALL have port wr_en, input, 1, writeback strobe.
REQ-011 SHALL have port wr_sel, input, SEL_BITS, writeback destination.
REQ-012 SHALL have port wr_scalar, input, 1; 1 = broadcast lane 0 of wr_data to all masked lanes, 0 = per-lane data.
REQ-013 SHALL have port wr_mask, input, LANES, per-lane write enable.
REQ-014 SHALL have port wr_data, input, LANES x REG_WIDTH, writeback data.
REQ-015 SHALL have ports iss_en, input, 1, and iss_sel, input, SEL_BITS; iss_en marks iss_sel as having an in-flight producer.
REQ-016 SHALL have port waw_err, output, 1, sticky flag for an issue to an already-busy register.

Function
REQ-017 Reads SHALL be combinational: operandN = contents of register rd_selN, zero latency.
REQ-018 With wr_en=1, each lane i with wr_mask[i]=1 SHALL load wr_data lane i (wr_scalar=0) or wr_data lane 0 (wr_scalar=1) at the next edge; unmasked lanes SHALL hold.
REQ-019 Register 0 SHALL read all-zero, ignore writes, never become busy, and never raise waw_err.
REQ-020 iss_en=1 SHALL set busy[iss_sel] at the next edge; wr_en=1 SHALL clear busy[wr_sel] at the next edge, regardless of wr_mask, including wr_mask=0.
REQ-021 Simultaneous iss_en and wr_en to the same register SHALL leave busy set, since the new producer takes precedence.
REQ-022 iss_en to a register whose busy is already 1, with no same-cycle clearing write to it, SHALL set waw_err at the next edge; waw_err SHALL remain set until rst.
REQ-023 busyN SHALL reflect the registered busy bit only; same-cycle iss_en/wr_en SHALL NOT affect it.

Reset
REQ-024 rst=1 at an edge SHALL zero every register lane, clear all busy bits and clear waw_err, overriding same-cycle wr_en and iss_en.
REQ-025 During reset, operand1/2 SHALL read zero and busy1/2 SHALL read 0 from the cycle after the reset edge.

Configuration
REQ-026 Macro VRF_BYPASS_EN defined: when wr_en=1, wr_sel==rd_selN and wr_sel!=0, operandN lanes with wr_mask set SHALL show the effective write data in the same cycle, and busyN SHALL read 0.
REQ-027 Macro VRF_BYPASS_EN undefined: operandN SHALL show pre-write contents until the edge, and busyN SHALL follow REQ-023.

Structure
REQ-028 Package vrf_pkg SHALL hold the default parameter constants and the lane-vector typedef (LANES x REG_WIDTH packed array).
REQ-029 Sub-module vrf_scoreboard SHALL own the busy bits and waw_err; storage and bypass SHALL stay in vec_regfile_sb.

Verification
REQ-030 Reset then read: rst for 1 cycle, then rd_sel1=3 -> operand1=0, busy1=0, waw_err=0.
REQ-031 Vector masked write: write R5 with wr_data={8'h44,8'h33,8'h22,8'h11} and wr_mask=4'b1111, then write R5 with wr_data all 8'hFF and wr_mask=4'b0101 -> read R5 = {44,FF,22,FF}.
REQ-032 Scalar broadcast: wr_scalar=1, wr_sel=2, lane0=8'h7A, wr_mask=4'b1111 -> R2 all lanes 8'h7A.
REQ-033 Scoreboard: iss R4 -> busy=1 next cycle; iss R4 again -> waw_err=1; write R4 together with iss R4 -> busy stays 1; write R4 alone -> busy=0; waw_err still 1.
REQ-034 R0: write 8'hAA to R0 with iss_en to R0 -> operand=0, busy=0, waw_err=0.
REQ-035 Bypass: wr_sel=rd_sel1=6, data 8'h5C -> VRF_BYPASS_EN: operand1=5C same cycle; undefined: old value, then 5C next cycle.
